// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   CORE_XLEN     : default datapath width of the RV32I core.
//   CORE_RESET_PC : default PC after reset.
//   fetch_entry_t : {pc, instr} record handed from fetch to decode at core width.
//   cnt_width()   : width of an occupancy counter able to hold 0..depth.
package fetch_prefetch_queue_pkg;

  localparam int unsigned CORE_XLEN = 32;
  localparam logic [CORE_XLEN-1:0] CORE_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with flush, used for both the instruction queue and the
// tag FIFO of issued fetch addresses.
//   clk, reset  : clock, asynchronous active-high reset
//   push, wdata : write at tail (ignored when full)
//   pop         : drop head (ignored when empty)
//   flush       : empty the FIFO; wins over push/pop in the same cycle
//   rdata       : head entry, combinational (no bypass from wdata)
//   count       : occupancy 0..DEPTH; full/empty derived from it
module fetch_prefetch_queue_sync_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             flush,
  input  logic [WIDTH-1:0]                 wdata,
  output logic [WIDTH-1:0]                 rdata,
  output logic [cnt_width(DEPTH)-1:0]      count,
  output logic                             full,
  output logic                             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue.
// Issues sequential word-aligned requests, buffers in-order responses with
// their PCs and hands them to decode over valid/ready. A redirect flushes the
// queue and discards responses still in flight for the old path.
//   clk, reset                     : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr      : request channel to instruction memory
//   imem_rsp_valid/data            : in-order response channel (always accepted)
//   id_valid/ready, id_pc/id_instr : queue head towards decode
//   redirect_valid, redirect_pc    : taken branch/jump target
//   align_err                      : one-cycle pulse after a misaligned redirect
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN     = CORE_XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(CORE_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            align_err
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned UW = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   qcount;
  logic [CW-1:0]   tag_count;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   inflight;
  logic [UW-1:0]   credit_used;
  logic            q_full;
  logic            q_empty;
  logic            tag_full;
  logic            tag_empty;
  logic [XLEN-1:0] tag_pc;
  entry_t          q_wdata;
  entry_t          q_rdata;
  logic            req_fire;
  logic            rsp_keep;
  logic            pop_fire;

  // Tags of dropped responses are flushed on redirect, so every outstanding
  // request is either still tagged or counted in drop.
  assign inflight    = tag_count + drop;
  assign credit_used = UW'(qcount) + UW'(inflight);

  // The full flags are implied by the credit sum; they only guard the FIFOs
  // against an out-of-protocol memory.
  always_comb begin
    imem_req_valid = !reset && !redirect_valid && (credit_used < UW'(DEPTH))
                     && !q_full && !tag_full;
  end

  assign imem_req_addr = pc;
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign rsp_keep      = imem_rsp_valid && (drop == '0) && !redirect_valid && !tag_empty;
  assign pop_fire      = id_valid && id_ready && !redirect_valid;

  assign q_wdata.pc    = tag_pc;
  assign q_wdata.instr = imem_rsp_data;

  assign id_valid = !q_empty;
  assign id_pc    = id_valid ? q_rdata.pc    : '0;
  assign id_instr = id_valid ? q_rdata.instr : '0;

  fetch_prefetch_queue_sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_keep),
    .pop   (pop_fire),
    .flush (redirect_valid),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (qcount),
    .full  (q_full),
    .empty (q_empty)
  );

  fetch_prefetch_queue_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk   (clk),
    .reset (reset),
    .push  (req_fire),
    .pop   (rsp_keep),
    .flush (redirect_valid),
    .wdata (pc),
    .rdata (tag_pc),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      drop      <= '0;
      align_err <= 1'b0;
    end else begin
      align_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        pc <= {redirect_pc[XLEN-1:2], 2'b00};
        // A response landing this cycle is already discarded, so it is
        // not counted again.
        drop <= inflight - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) pc <= pc + XLEN'(4);
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        align_err;

  int n_checks = 0;
  int n_fail = 0;
  int lat = 1;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .align_err      (align_err)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: fixed latency, in-order, one response per cycle.
  logic        hs_pre = 1'b0;
  logic [31:0] hs_addr_pre = '0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          edge_n = 0;

  always @(negedge clk) begin
    #3;
    hs_pre      = imem_req_valid && imem_req_ready;
    hs_addr_pre = imem_req_addr;
  end

  always @(posedge clk) begin
    if (reset) begin
      mq_addr.delete();
      mq_due.delete();
      edge_n = 0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
    end else begin
      if (hs_pre) begin
        mq_addr.push_back(hs_addr_pre);
        mq_due.push_back(edge_n + lat - 1);
      end
      #1;
      if (mq_addr.size() != 0 && mq_due[0] <= edge_n) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = instr_of(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      edge_n++;
    end
  end

  task automatic do_reset(input int l);
    lat = l;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    imem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    imem_req_ready = 1'b1;
    lat = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr got=%h exp=00000000", imem_req_addr); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc got=%h exp=00000000", id_pc); end
    n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_id_instr got=%h exp=00000000", id_instr); end
    n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL reset_align_err got=%b exp=0", align_err); end
    reset = 1'b0;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_release_valid got=%b exp=1", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_release_addr got=%h exp=00000000", imem_req_addr); end
  endtask

  // Latency 1, decode always ready: head valid from the third sample on.
  task automatic test_steady_stream;
    logic [31:0] e;
    do_reset(1);
    id_ready = 1'b1;
    for (int s = 0; s < 14; s++) begin
      if (s != 0) @(negedge clk);
      #1;
      e = 32'(4 * s);
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== e) begin n_fail++; $display("FAIL steady_req s=%0d got=%b/%h exp=1/%h", s, imem_req_valid, imem_req_addr, e); end
      if (s < 2) begin
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL steady_early_valid s=%0d got=%b exp=0", s, id_valid); end
      end else begin
        e = 32'(4 * (s - 2));
        n_checks++; if (id_valid !== 1'b1 || id_pc !== e) begin n_fail++; $display("FAIL steady_head s=%0d got=%b/%h exp=1/%h", s, id_valid, id_pc, e); end
        n_checks++; if (id_instr !== instr_of(e)) begin n_fail++; $display("FAIL steady_instr s=%0d got=%h exp=%h", s, id_instr, instr_of(e)); end
      end
    end
  endtask

  task automatic test_back_pressure;
    int          nhs;
    int          pops;
    bit          seen_req;
    logic [31:0] e;
    do_reset(1);
    nhs = 0;
    for (int s = 0; s < 20; s++) begin
      if (s != 0) @(negedge clk);
      #1;
      if (imem_req_valid && imem_req_ready) nhs++;
    end
    n_checks++; if (nhs !== 4) begin n_fail++; $display("FAIL bp_request_count got=%0d exp=4", nhs); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_stalled got=%b exp=0", imem_req_valid); end
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head_held got=%b/%h exp=1/00000000", id_valid, id_pc); end
    pops = 0;
    seen_req = 1'b0;
    e = 32'h0;
    for (int s = 0; s < 40 && !(pops >= 8 && seen_req); s++) begin
      @(negedge clk);
      id_ready = 1'b1;
      #1;
      if (imem_req_valid && !seen_req) begin
        seen_req = 1'b1;
        n_checks++; if (imem_req_addr !== 32'h10) begin n_fail++; $display("FAIL bp_resume_addr got=%h exp=00000010", imem_req_addr); end
      end
      if (id_valid && pops < 8) begin
        n_checks++; if (id_pc !== e || id_instr !== instr_of(e)) begin n_fail++; $display("FAIL bp_drain_order got=%h/%h exp=%h/%h", id_pc, id_instr, e, instr_of(e)); end
        e = e + 32'h4;
        pops++;
      end
    end
    n_checks++; if (pops < 8 || !seen_req) begin n_fail++; $display("FAIL bp_drain_timeout got=%0d pops exp=8", pops); end
  endtask

  // Latency 3: responses for 0x0 and 0x4 are in flight at the redirect.
  task automatic test_redirect_inflight;
    int          pops;
    logic [31:0] e;
    do_reset(3);
    id_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      if (s != 0) @(negedge clk);
      redirect_valid = (s == 2);
      redirect_pc = 32'h100;
      #1;
      if (s == 2) begin
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdi_no_req got=%b exp=0", imem_req_valid); end
      end
      if (s == 3) begin
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL rdi_new_req got=%b/%h exp=1/00000100", imem_req_valid, imem_req_addr); end
      end
      if (s >= 3 && s <= 6) begin
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rdi_stale_visible s=%0d got=%b/%h exp=0", s, id_valid, id_pc); end
      end
      if (s == 7) begin
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== instr_of(32'h100)) begin n_fail++; $display("FAIL rdi_first_head got=%b/%h/%h exp=1/00000100/%h", id_valid, id_pc, id_instr, instr_of(32'h100)); end
      end
    end
    pops = 0;
    e = 32'h104;
    for (int s = 0; s < 20 && pops < 3; s++) begin
      @(negedge clk);
      #1;
      if (id_valid) begin
        n_checks++; if (id_pc !== e || id_instr !== instr_of(e)) begin n_fail++; $display("FAIL rdi_follow got=%h/%h exp=%h/%h", id_pc, id_instr, e, instr_of(e)); end
        e = e + 32'h4;
        pops++;
      end
    end
    n_checks++; if (pops < 3) begin n_fail++; $display("FAIL rdi_follow_timeout got=%0d exp=3", pops); end
  endtask

  // Redirect in a cycle that also has a response and a pop (latency 1).
  task automatic test_redirect_collide(input logic [31:0] target);
    do_reset(1);
    id_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      if (s != 0) @(negedge clk);
      redirect_valid = (s == 4);
      redirect_pc = target;
      #1;
      if (s == 4) begin
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL col_no_req got=%b exp=0", imem_req_valid); end
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || imem_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL col_old_head got=%b/%h rsp=%b exp=1/00000008 rsp=1", id_valid, id_pc, imem_rsp_valid); end
        n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL col_align_early got=%b exp=0", align_err); end
      end
      if (s == 5) begin
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL col_flushed got=%b exp=0", id_valid); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL col_new_req got=%b/%h exp=1/00000100", imem_req_valid, imem_req_addr); end
        n_checks++; if (align_err !== (target[1:0] != 2'b00)) begin n_fail++; $display("FAIL col_align_pulse got=%b exp=%b", align_err, target[1:0] != 2'b00); end
      end
      if (s == 6) begin
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL col_still_empty got=%b exp=0", id_valid); end
        n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL col_align_end got=%b exp=0", align_err); end
      end
      if (s == 7) begin
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== instr_of(32'h100)) begin n_fail++; $display("FAIL col_first_head got=%b/%h/%h exp=1/00000100/%h", id_valid, id_pc, id_instr, instr_of(32'h100)); end
      end
    end
  endtask

  task automatic test_pc_wrap;
    logic [31:0] e;
    do_reset(1);
    id_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      if (s != 0) @(negedge clk);
      redirect_valid = (s == 2);
      redirect_pc = 32'hFFFF_FFF8;
      #1;
      if (s >= 3 && s <= 5) begin
        e = 32'hFFFF_FFF8 + 32'(4 * (s - 3));
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== e) begin n_fail++; $display("FAIL wrap_req s=%0d got=%b/%h exp=1/%h", s, imem_req_valid, imem_req_addr, e); end
      end
      if (s >= 5) begin
        e = 32'hFFFF_FFF8 + 32'(4 * (s - 5));
        n_checks++; if (id_valid !== 1'b1 || id_pc !== e || id_instr !== instr_of(e)) begin n_fail++; $display("FAIL wrap_head s=%0d got=%b/%h/%h exp=1/%h/%h", s, id_valid, id_pc, id_instr, e, instr_of(e)); end
      end
    end
  endtask

  task automatic test_async_reset;
    do_reset(1);
    id_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      if (s != 0) @(negedge clk);
      #1;
    end
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'hC) begin n_fail++; $display("FAIL areset_pre got=%b/%h exp=1/0000000c", id_valid, id_pc); end
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL areset_req got=%b/%h exp=0/00000000", imem_req_valid, imem_req_addr); end
    n_checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0) begin n_fail++; $display("FAIL areset_id got=%b/%h/%h exp=0/0/0", id_valid, id_pc, id_instr); end
    n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL areset_align got=%b exp=0", align_err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL areset_first_req got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr); end
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== instr_of(32'h0)) begin n_fail++; $display("FAIL areset_restart got=%b/%h/%h exp=1/00000000/%h", id_valid, id_pc, id_instr, instr_of(32'h0)); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_steady_stream();
    test_back_pressure();
    test_redirect_inflight();
    test_redirect_collide(32'h100);
    test_redirect_collide(32'h102);
    test_pc_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
